// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and constants for the score display controller
// Purpose: FSM state encoding, blank glyph code and default geometry parameters.
// Ports: none (package).
package score_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADD0    = 3'd1,
    ADD1    = 3'd2,
    ADD2    = 3'd3,
    PUBLISH = 3'd4
  } state_t;

  localparam int BLANK_CODE  = 10;
  localparam int GLYPH_PITCH = 4;
  localparam int ROW_W       = 16;
  localparam int MAX_BASE    = 694;

endpackage

// File: rtl/score_ctrl_bcd_digit_add.sv
// rtl/score_ctrl_bcd_digit_add.sv - single BCD digit adder with carry in/out
// Purpose: digit + addend + carry_in, wrapped into 0..9 with a decimal carry.
// Ports: digit, addend (BCD 0..9), carry_in -> sum (BCD 0..9), carry_out.
module bcd_digit_add (
  input  logic [3:0] digit,
  input  logic [3:0] addend,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out
);

  logic [4:0] raw;

  // Max raw value is 9+9+1 = 19, so a single subtract of 10 suffices.
  always_comb begin
    raw = {1'b0, digit} + {1'b0, addend} + {4'd0, carry_in};
    if (raw >= 5'd10) begin
      sum       = 4'(raw - 5'd10);
      carry_out = 1'b1;
    end else begin
      sum       = raw[3:0];
      carry_out = 1'b0;
    end
  end

endmodule

// File: rtl/score_ctrl.sv
// rtl/score_ctrl.sv - three-digit BCD score keeper with glyph placement for a renderer
// Purpose: accumulate saturating 0..999 score, track high score, publish blanked
//          glyph codes and bitmap origins to a renderer through a valid/ack handshake.
// Ports: clk, reset (sync, active-high); add_req/add_val/add_rdy add interface;
//        clear; pos_load/pos_base/pos_err base loading; digit1..3 glyph codes;
//        step1..3 bitmap origins; upd_valid/upd_ack publish handshake; busy; hi_flag.
module score_ctrl #(
  parameter int GLYPH_PITCH = score_pkg::GLYPH_PITCH,
  parameter int ROW_W       = score_pkg::ROW_W,
  parameter int MAX_BASE    = score_pkg::MAX_BASE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       add_req,
  input  logic [3:0] add_val,
  output logic       add_rdy,
  input  logic       clear,
  input  logic       pos_load,
  input  logic [9:0] pos_base,
  output logic       pos_err,
  output logic [9:0] digit1,
  output logic [9:0] digit2,
  output logic [9:0] digit3,
  output logic [9:0] step1,
  output logic [9:0] step2,
  output logic [9:0] step3,
  output logic       upd_valid,
  input  logic       upd_ack,
  output logic       busy,
  output logic       hi_flag
);

  import score_pkg::*;

  state_t     state;
  logic [3:0] hund, tens, ones;
  logic [3:0] addv;
  logic       carry;
  logic [9:0] base;
  logic [11:0] hi_score;

  // Shared digit adder operands, steered by the current ADD state.
  logic [3:0] add_digit, add_addend, add_sum;
  logic       add_cin, add_cout;

  always_comb begin
    add_digit  = ones;
    add_addend = 4'd0;
    add_cin    = 1'b0;
    case (state)
      ADD0: begin
        add_digit  = ones;
        add_addend = addv;
      end
      ADD1: begin
        add_digit = tens;
        add_cin   = carry;
      end
      ADD2: begin
        add_digit = hund;
        add_cin   = carry;
      end
      default: ;
    endcase
  end

  bcd_digit_add u_digit_add (
    .digit     (add_digit),
    .addend    (add_addend),
    .carry_in  (add_cin),
    .sum       (add_sum),
    .carry_out (add_cout)
  );

  logic pos_ok, pos_accept;
  assign pos_ok = (pos_base <= 10'(MAX_BASE)) &&
                  (((int'(pos_base) % ROW_W) + 2 * GLYPH_PITCH + 2) < ROW_W);
  // Clear and add both pre-empt a base load; anything not accepted is an error.
  assign pos_accept = pos_load && !clear && (state == IDLE) && !add_req && pos_ok;

  // Score as it will stand once PUBLISH is (re)entered on this edge.
  logic [3:0]  ent_h, ent_t, ent_o;
  logic [11:0] ent_score, ent_hi;
  logic        ent_flag;

  always_comb begin
    ent_h = hund;
    ent_t = tens;
    ent_o = ones;
    if (clear) begin
      ent_h = 4'd0;
      ent_t = 4'd0;
      ent_o = 4'd0;
    end else if (state == ADD2) begin
      if (add_cout) begin
        ent_h = 4'd9;
        ent_t = 4'd9;
        ent_o = 4'd9;
      end else begin
        ent_h = add_sum;
      end
    end
    ent_score = {ent_h, ent_t, ent_o};
    // BCD ordering matches numeric ordering, so a plain compare works.
    ent_hi    = (ent_score > hi_score) ? ent_score : hi_score;
    ent_flag  = (ent_score == ent_hi) && (ent_score != 12'd0);
  end

  logic [9:0] ent_d1, ent_d2, ent_d3;
  always_comb begin
    ent_d1 = (ent_h == 4'd0) ? 10'(BLANK_CODE) : {6'd0, ent_h};
    ent_d2 = (ent_h == 4'd0 && ent_t == 4'd0) ? 10'(BLANK_CODE) : {6'd0, ent_t};
    ent_d3 = {6'd0, ent_o};
  end

  logic enter_pub;
  assign enter_pub = clear || pos_accept || (state == ADD2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hund      <= 4'd0;
      tens      <= 4'd0;
      ones      <= 4'd0;
      addv      <= 4'd0;
      carry     <= 1'b0;
      base      <= 10'd0;
      hi_score  <= 12'd0;
      digit1    <= 10'(BLANK_CODE);
      digit2    <= 10'(BLANK_CODE);
      digit3    <= 10'd0;
      step1     <= 10'd0;
      step2     <= 10'(GLYPH_PITCH);
      step3     <= 10'(2 * GLYPH_PITCH);
      upd_valid <= 1'b0;
      busy      <= 1'b0;
      pos_err   <= 1'b0;
      hi_flag   <= 1'b0;
      add_rdy   <= 1'b1;
    end else begin
      pos_err <= pos_load && !pos_accept;

      if (enter_pub) begin
        state     <= PUBLISH;
        hund      <= ent_h;
        tens      <= ent_t;
        ones      <= ent_o;
        carry     <= 1'b0;
        hi_score  <= ent_hi;
        hi_flag   <= ent_flag;
        digit1    <= ent_d1;
        digit2    <= ent_d2;
        digit3    <= ent_d3;
        upd_valid <= 1'b1;
        busy      <= 1'b1;
        add_rdy   <= 1'b0;
        if (pos_accept) begin
          base  <= pos_base;
          step1 <= pos_base;
          step2 <= pos_base + 10'(GLYPH_PITCH);
          step3 <= pos_base + 10'(2 * GLYPH_PITCH);
        end
      end else begin
        case (state)
          IDLE: begin
            if (add_req) begin
              addv    <= (add_val > 4'd9) ? 4'd9 : add_val;
              state   <= ADD0;
              busy    <= 1'b1;
              add_rdy <= 1'b0;
            end
          end
          ADD0: begin
            ones  <= add_sum;
            carry <= add_cout;
            state <= ADD1;
          end
          ADD1: begin
            tens  <= add_sum;
            carry <= add_cout;
            state <= ADD2;
          end
          PUBLISH: begin
            if (upd_ack) begin
              state     <= IDLE;
              upd_valid <= 1'b0;
              busy      <= 1'b0;
              add_rdy   <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_ctrl.sv
// tb/tb_score_ctrl.sv - directed self-checking bench for score_ctrl
module tb_score_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       add_req;
  logic [3:0] add_val;
  logic       add_rdy;
  logic       clear;
  logic       pos_load;
  logic [9:0] pos_base;
  logic       pos_err;
  logic [9:0] digit1, digit2, digit3;
  logic [9:0] step1, step2, step3;
  logic       upd_valid;
  logic       upd_ack;
  logic       busy;
  logic       hi_flag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .add_req   (add_req),
    .add_val   (add_val),
    .add_rdy   (add_rdy),
    .clear     (clear),
    .pos_load  (pos_load),
    .pos_base  (pos_base),
    .pos_err   (pos_err),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .step1     (step1),
    .step2     (step2),
    .step3     (step3),
    .upd_valid (upd_valid),
    .upd_ack   (upd_ack),
    .busy      (busy),
    .hi_flag   (hi_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_digits(input string tag, input int d1, input int d2, input int d3);
    check({tag, ".d1"}, 32'(digit1), 32'(d1));
    check({tag, ".d2"}, 32'(digit2), 32'(d2));
    check({tag, ".d3"}, 32'(digit3), 32'(d3));
  endtask

  task automatic check_steps(input string tag, input int s1, input int s2, input int s3);
    check({tag, ".s1"}, 32'(step1), 32'(s1));
    check({tag, ".s2"}, 32'(step2), 32'(s2));
    check({tag, ".s3"}, 32'(step3), 32'(s3));
  endtask

  // Full add with upd_ack held high: accept, 3 ADD edges, publish, back to IDLE.
  task automatic run_add(input logic [3:0] v);
    @(negedge clk);
    add_req = 1'b1;
    add_val = v;
    @(negedge clk);
    add_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_pos(input logic [9:0] b);
    @(negedge clk);
    pos_load = 1'b1;
    pos_base = b;
    @(negedge clk);
    pos_load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; add_req = 1'b0; add_val = 4'd0; clear = 1'b0;
    pos_load = 1'b0; pos_base = 10'd0; upd_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_digits("rst", 10, 10, 0);
    check_steps("rst", 0, 4, 8);
    check("rst.upd_valid", 32'(upd_valid), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.pos_err", 32'(pos_err), 0);
    check("rst.hi_flag", 32'(hi_flag), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst.add_rdy", 32'(add_rdy), 1);

    // Add 7: upd_valid appears exactly 3 edges after acceptance.
    add_req = 1'b1; add_val = 4'd7;
    @(negedge clk); add_req = 1'b0;
    check("add7.e0.valid", 32'(upd_valid), 0);
    check("add7.e0.busy", 32'(busy), 1);
    @(negedge clk); check("add7.e1.valid", 32'(upd_valid), 0);
    @(negedge clk); check("add7.e2.valid", 32'(upd_valid), 0);
    @(negedge clk); check("add7.e3.valid", 32'(upd_valid), 1);
    check_digits("add7", 10, 10, 7);
    check_steps("add7", 0, 4, 8);
    check("add7.hi_flag", 32'(hi_flag), 1);
    @(negedge clk); check("add7.e4.valid", 32'(upd_valid), 0);
    check("add7.e4.add_rdy", 32'(add_rdy), 1);

    // 7 + 9*9 (add_val 15 clamps to 9) + 7 = 95
    for (int i = 0; i < 9; i++) run_add(4'hF);
    check_digits("s88", 10, 8, 8);
    run_add(4'd7);
    check_digits("s95", 10, 9, 5);
    run_add(4'd9);
    check_digits("s104", 1, 0, 4);
    check("s104.hi_flag", 32'(hi_flag), 1);

    // 104 + 99*9 = 995, then saturate.
    for (int i = 0; i < 99; i++) run_add(4'd9);
    check_digits("s995", 9, 9, 5);
    run_add(4'd9);
    check_digits("sat", 9, 9, 9);
    run_add(4'd1);
    check_digits("sat2", 9, 9, 9);
    check("sat2.hi_flag", 32'(hi_flag), 1);

    // Base loading.
    @(negedge clk); pos_load = 1'b1; pos_base = 10'd21;
    @(negedge clk); pos_load = 1'b0;
    check("pos21.err", 32'(pos_err), 0);
    check("pos21.valid", 32'(upd_valid), 1);
    check_steps("pos21", 21, 25, 29);
    check_digits("pos21", 9, 9, 9);
    @(negedge clk);
    do_pos(10'd700);
    check("pos700.err", 32'(pos_err), 1);
    check("pos700.busy", 32'(busy), 0);
    check_steps("pos700", 21, 25, 29);
    @(negedge clk);
    check("pos700.err_drop", 32'(pos_err), 0);
    do_pos(10'd12);
    check("pos12.err", 32'(pos_err), 1);
    check_steps("pos12", 21, 25, 29);
    @(negedge clk);

    // Clear during ADD1 of a pending add.
    add_req = 1'b1; add_val = 4'd5;
    @(negedge clk); add_req = 1'b0;
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    check("clr.valid", 32'(upd_valid), 1);
    check_digits("clr", 10, 10, 0);
    check("clr.hi_flag", 32'(hi_flag), 0);
    @(negedge clk);
    run_add(4'd7);
    check_digits("clr.add7", 10, 10, 7);
    check("clr.hi_kept", 32'(hi_flag), 0);

    // Renderer stalls: PUBLISH holds, adds are refused.
    upd_ack = 1'b0;
    @(negedge clk); add_req = 1'b1; add_val = 4'd2;
    @(negedge clk); add_req = 1'b0;
    repeat (3) @(negedge clk);
    check("stall.valid0", 32'(upd_valid), 1);
    check_digits("stall0", 10, 10, 9);
    for (int i = 0; i < 10; i++) begin
      add_req = (i % 2 == 0); add_val = 4'd3;
      @(negedge clk);
      check("stall.valid", 32'(upd_valid), 1);
      check("stall.add_rdy", 32'(add_rdy), 0);
      check("stall.d3", 32'(digit3), 9);
    end
    add_req = 1'b0; upd_ack = 1'b1;
    @(negedge clk);
    check("stall.release.busy", 32'(busy), 0);
    check("stall.release.rdy", 32'(add_rdy), 1);
    check_digits("stall.release", 10, 10, 9);

    // Clear during PUBLISH with coincident ack stays in PUBLISH.
    upd_ack = 1'b0;
    do_pos(10'd0);
    check("pub.valid", 32'(upd_valid), 1);
    clear = 1'b1; upd_ack = 1'b1;
    @(negedge clk); clear = 1'b0;
    check("pubclr.valid", 32'(upd_valid), 1);
    check_digits("pubclr", 10, 10, 0);
    check_steps("pubclr", 0, 4, 8);
    @(negedge clk);
    check("pubclr.exit", 32'(upd_valid), 0);

    // Reset mid-add.
    run_add(4'd6);
    add_req = 1'b1; add_val = 4'd4;
    @(negedge clk); add_req = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("midrst.busy", 32'(busy), 0);
    check("midrst.valid", 32'(upd_valid), 0);
    check_digits("midrst", 10, 10, 0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst.add_rdy", 32'(add_rdy), 1);
    check("midrst.hi_flag", 32'(hi_flag), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
